// File: rtl/input_conditioner.sv
// Input front end: two-flop synchronizer, polarity fix-up and per-channel
// debounce, producing clean levels plus single-cycle rise/fall pulses.
module input_conditioner #(
    parameter int unsigned     N_CH      = 6,
    parameter int unsigned     DB_CYCLES = 16,
    parameter int unsigned     CNT_W     = 5,
    parameter logic [N_CH-1:0] INV_MASK  = {{(N_CH-1){1'b0}}, 1'b1}
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_in,
    input  logic            sample_en,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    output logic            any_change
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [N_CH-1:0]  sync1_q, sync2_q;
    logic [N_CH-1:0]  s;
    logic [N_CH-1:0]  level_q, level_d;
    logic [N_CH-1:0]  rise_q, rise_d;
    logic [N_CH-1:0]  fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    // Loading INV_MASK makes the post-inversion value 0 while in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= INV_MASK;
            sync2_q <= INV_MASK;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q ^ INV_MASK;

    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sample_en) begin
                if (s[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    cnt_d[i]   = '0;
                    level_d[i] = s[i];
                    rise_d[i]  = s[i];
                    fall_d[i]  = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign any_change = |{rise_q, fall_q};

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed segment table plus randomized run
// against a sliding-window reference model.
module tb_input_conditioner;

    localparam int         N   = 6;
    localparam int         DB  = 4;
    localparam logic [5:0] INV = 6'b000001;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_en;
    logic [5:0] raw_in;
    logic [5:0] level_out, rise_pulse, fall_pulse;
    logic       any_change;

    always #5 clk = ~clk;

    input_conditioner #(
        .N_CH(N), .DB_CYCLES(DB), .CNT_W(3), .INV_MASK(INV)
    ) dut (
        .clk(clk), .reset(reset), .raw_in(raw_in), .sample_en(sample_en),
        .level_out(level_out), .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse), .any_change(any_change)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: raw value as seen two edges ago, and per channel a
    // window of the last DB enabled samples taken since the last acceptance.
    logic [5:0]    m_level, m_rise, m_fall;
    logic [5:0]    d1, d2;
    logic [DB-1:0] win [N];
    int            nvalid [N];

    logic [5:0] rise_acc, fall_acc;
    int         any_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic e, input logic [5:0] raw);
        logic [5:0] s;
        m_rise = '0;
        m_fall = '0;
        if (r) begin
            m_level = '0;
            d1 = INV;
            d2 = INV;
            for (int i = 0; i < N; i++) begin
                win[i] = '0;
                nvalid[i] = 0;
            end
        end else begin
            s = d2 ^ INV;
            if (e) begin
                for (int i = 0; i < N; i++) begin
                    win[i] = {win[i][DB-2:0], s[i]};
                    if (nvalid[i] < DB) nvalid[i]++;
                    if (nvalid[i] >= DB && win[i] == {DB{~m_level[i]}}) begin
                        m_level[i] = s[i];
                        if (s[i]) m_rise[i] = 1'b1;
                        else      m_fall[i] = 1'b1;
                        nvalid[i] = 0;
                    end
                end
            end
            d2 = d1;
            d1 = raw;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [5:0] raw);
        reset     = r;
        sample_en = e;
        raw_in    = raw;
        @(posedge clk);
        model_edge(r, e, raw);
        #1;
        chk("model_level", {26'b0, level_out}, {26'b0, m_level});
        chk("model_rise", {26'b0, rise_pulse}, {26'b0, m_rise});
        chk("model_fall", {26'b0, fall_pulse}, {26'b0, m_fall});
        chk("model_any", {31'b0, any_change}, {31'b0, |{m_rise, m_fall}});
        rise_acc = rise_acc | rise_pulse;
        fall_acc = fall_acc | fall_pulse;
        if (any_change === 1'b1) any_cnt++;
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [5:0] raw;
        int         n;
        logic [5:0] lvl;
        logic [5:0] rise;
        logic [5:0] fall;
        int         anys;
    } seg_t;

    seg_t tbl[$];

    task automatic add(input logic r, input logic e, input logic [5:0] raw, input int n,
                       input logic [5:0] lvl, input logic [5:0] rise,
                       input logic [5:0] fall, input int anys);
        seg_t sg;
        sg.rst = r; sg.en = e; sg.raw = raw; sg.n = n;
        sg.lvl = lvl; sg.rise = rise; sg.fall = fall; sg.anys = anys;
        tbl.push_back(sg);
    endtask

    logic [5:0] rr;
    logic [2:0] b;
    logic       ren, rrst;

    initial begin
        // 1: reset then idle, nothing must happen
        add(1, 1, 6'b000001, 3, 6'b0, 6'b0, 6'b0, 0);
        add(0, 1, 6'b000001, 20, 6'b0, 6'b0, 6'b0, 0);
        // 2: accept on 6th edge, pulse exactly one cycle, then fall
        add(0, 1, 6'b000011, 5, 6'b0, 6'b0, 6'b0, 0);
        add(0, 1, 6'b000011, 1, 6'b000010, 6'b000010, 6'b0, 1);
        add(0, 1, 6'b000011, 4, 6'b000010, 6'b0, 6'b0, 0);
        add(0, 1, 6'b000001, 5, 6'b000010, 6'b0, 6'b0, 0);
        add(0, 1, 6'b000001, 1, 6'b0, 6'b0, 6'b000010, 1);
        // 3: glitch of DB-1 samples is rejected
        add(0, 1, 6'b000101, 3, 6'b0, 6'b0, 6'b0, 0);
        add(0, 1, 6'b000001, 10, 6'b0, 6'b0, 6'b0, 0);
        // 4: bounce every 2 cycles, then settle high
        for (int k = 0; k < 3; k++) begin
            add(0, 1, 6'b001001, 2, 6'b0, 6'b0, 6'b0, 0);
            add(0, 1, 6'b000001, 2, 6'b0, 6'b0, 6'b0, 0);
        end
        add(0, 1, 6'b001001, 5, 6'b0, 6'b0, 6'b0, 0);
        add(0, 1, 6'b001001, 1, 6'b001000, 6'b001000, 6'b0, 1);
        add(0, 1, 6'b000001, 5, 6'b001000, 6'b0, 6'b0, 0);
        add(0, 1, 6'b000001, 1, 6'b0, 6'b0, 6'b001000, 1);
        // 5: active-low start, then three channels in the same cycle
        add(0, 1, 6'b000000, 5, 6'b0, 6'b0, 6'b0, 0);
        add(0, 1, 6'b000000, 1, 6'b000001, 6'b000001, 6'b0, 1);
        add(0, 1, 6'b000001, 5, 6'b000001, 6'b0, 6'b0, 0);
        add(0, 1, 6'b000001, 1, 6'b0, 6'b0, 6'b000001, 1);
        add(0, 1, 6'b110000, 5, 6'b0, 6'b0, 6'b0, 0);
        add(0, 1, 6'b110000, 1, 6'b110001, 6'b110001, 6'b0, 1);
        add(0, 1, 6'b000001, 5, 6'b110001, 6'b0, 6'b0, 0);
        add(0, 1, 6'b000001, 1, 6'b0, 6'b0, 6'b110001, 1);
        // 6a: sample_en one cycle in four
        add(0, 0, 6'b000011, 2, 6'b0, 6'b0, 6'b0, 0);
        for (int k = 0; k < 3; k++) begin
            add(0, 1, 6'b000011, 1, 6'b0, 6'b0, 6'b0, 0);
            add(0, 0, 6'b000011, 3, 6'b0, 6'b0, 6'b0, 0);
        end
        add(0, 1, 6'b000011, 1, 6'b000010, 6'b000010, 6'b0, 1);
        add(0, 0, 6'b000011, 3, 6'b000010, 6'b0, 6'b0, 0);
        add(0, 1, 6'b000001, 5, 6'b000010, 6'b0, 6'b0, 0);
        add(0, 1, 6'b000001, 1, 6'b0, 6'b0, 6'b000010, 1);
        // 6b: reset after 2 ticks discards the partial count
        add(0, 0, 6'b000011, 2, 6'b0, 6'b0, 6'b0, 0);
        for (int k = 0; k < 2; k++) begin
            add(0, 1, 6'b000011, 1, 6'b0, 6'b0, 6'b0, 0);
            add(0, 0, 6'b000011, 3, 6'b0, 6'b0, 6'b0, 0);
        end
        add(1, 1, 6'b000011, 1, 6'b0, 6'b0, 6'b0, 0);
        add(0, 0, 6'b000011, 2, 6'b0, 6'b0, 6'b0, 0);
        for (int k = 0; k < 3; k++) begin
            add(0, 1, 6'b000011, 1, 6'b0, 6'b0, 6'b0, 0);
            add(0, 0, 6'b000011, 3, 6'b0, 6'b0, 6'b0, 0);
        end
        add(0, 1, 6'b000011, 1, 6'b000010, 6'b000010, 6'b0, 1);
        add(0, 0, 6'b000011, 3, 6'b000010, 6'b0, 6'b0, 0);
        // reset while a level is high: no fall pulse, full re-acceptance
        add(1, 1, 6'b000011, 2, 6'b0, 6'b0, 6'b0, 0);
        add(0, 1, 6'b000011, 5, 6'b0, 6'b0, 6'b0, 0);
        add(0, 1, 6'b000011, 1, 6'b000010, 6'b000010, 6'b0, 1);
        add(0, 1, 6'b000001, 5, 6'b000010, 6'b0, 6'b0, 0);
        add(0, 1, 6'b000001, 1, 6'b0, 6'b0, 6'b000010, 1);

        foreach (tbl[j]) begin
            rise_acc = '0;
            fall_acc = '0;
            any_cnt  = 0;
            repeat (tbl[j].n) step(tbl[j].rst, tbl[j].en, tbl[j].raw);
            chk($sformatf("seg%0d_level", j), {26'b0, level_out}, {26'b0, tbl[j].lvl});
            chk($sformatf("seg%0d_rise", j), {26'b0, rise_acc}, {26'b0, tbl[j].rise});
            chk($sformatf("seg%0d_fall", j), {26'b0, fall_acc}, {26'b0, tbl[j].fall});
            chk($sformatf("seg%0d_anycnt", j), any_cnt, tbl[j].anys);
        end

        // Randomized run: slowly wandering pins, gated sampling, rare resets
        rr = 6'b000001;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(11) == 0) begin
                b = 3'($urandom_range(5));
                rr[b] = ~rr[b];
            end
            ren  = ($urandom_range(3) != 0);
            rrst = ($urandom_range(399) == 0);
            step(rrst, ren, rr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
